// File: rtl/rv32i_disassembler.sv
// rtl/rv32i_disassembler.sv - RV32I instruction word to ASCII assembly line streamer
//
// Purpose: accepts one 32-bit RV32I word at a time and streams its assembly text,
// one byte per transfer, terminated by LINE_END. Undecodable words print as
// "unknown 0x<word>" and are flagged on illegal_out alongside line_done_out.
//
// Ports:
//   clk_in          in   1   system clock
//   rst_in          in   1   synchronous, active-high reset
//   inst_in         in   32  instruction word
//   inst_valid_in   in   1   inst_in is valid
//   inst_ready_out  out  1   word can be accepted (IDLE and not in reset)
//   char_out        out  8   ASCII character
//   char_valid_out  out  1   char_out is valid
//   char_ready_in   in   1   downstream accepts char_out
//   line_done_out   out  1   pulse in the cycle LINE_END is accepted
//   illegal_out     out  1   with line_done_out: word was undecodable
module rv32i_disassembler #(
    parameter int         UPPER_HEX = 0,
    parameter logic [7:0] LINE_END  = 8'h0A
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] inst_in,
    input  logic        inst_valid_in,
    output logic        inst_ready_out,
    output logic [7:0]  char_out,
    output logic        char_valid_out,
    input  logic        char_ready_in,
    output logic        line_done_out,
    output logic        illegal_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_MNEM   = 3'd2;
    localparam logic [2:0] S_OPS    = 3'd3;
    localparam logic [2:0] S_EOL    = 3'd4;

    // Operand token kinds: a register, a bare immediate, or "imm(reg)".
    localparam logic [1:0] K_REG = 2'd0;
    localparam logic [1:0] K_IMM = 2'd1;
    localparam logic [1:0] K_MEM = 2'd2;

    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [2:0]  state;
    logic [31:0] inst_r;

    // Decoded line description, captured at the end of DECODE.
    logic [63:0] mnem_r;        // mnemonic, right-justified, first char in the highest used byte
    logic [2:0]  mlen_r;
    logic [7:0]  kinds_r;       // token kinds, slot 0 in the low bits
    logic [19:0] regs_r;        // token register numbers, slot 0 in the low bits
    logic [31:0] imm_r;
    logic [1:0]  ntok_r;
    logic        illegal_r;

    // Output cursor: which character of the line is currently presented.
    logic [2:0]  m_idx;
    logic [1:0]  tok;
    logic [4:0]  pos;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return (UPPER_HEX != 0 ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    function automatic logic [4:0] reg_len(input logic [4:0] r);
        return (r >= 5'd10) ? 5'd3 : 5'd2;
    endfunction

    function automatic logic [7:0] reg_char(input logic [4:0] r, input logic [4:0] p);
        logic [4:0] tens;
        logic [4:0] ones;
        if (r >= 5'd30)      tens = 5'd3;
        else if (r >= 5'd20) tens = 5'd2;
        else if (r >= 5'd10) tens = 5'd1;
        else                 tens = 5'd0;
        ones = r - 5'd10 * tens;
        if (p == 5'd0) return "x";
        if (tens == 5'd0 || p != 5'd1) return 8'h30 + {3'd0, ones};
        return 8'h30 + {3'd0, tens};
    endfunction

    function automatic logic [7:0] imm_char(input logic [31:0] v, input logic [4:0] p);
        logic [2:0] ni;
        ni = 3'(5'd9 - p);
        if (p == 5'd0) return "0";
        if (p == 5'd1) return "x";
        return hex_char(v[{ni, 2'b00} +: 4]);
    endfunction

    function automatic logic [4:0] tok_len(input logic [1:0] k, input logic [4:0] r);
        case (k)
            K_REG:   return reg_len(r);
            K_IMM:   return 5'd10;
            default: return 5'd12 + reg_len(r);
        endcase
    endfunction

    function automatic logic [7:0] tok_char(input logic [1:0] k, input logic [4:0] r,
                                            input logic [31:0] v, input logic [4:0] p);
        if (k == K_REG) return reg_char(r, p);
        if (k == K_IMM || p < 5'd10) return imm_char(v, p);
        if (p == 5'd10) return "(";
        if (p == 5'd11 + reg_len(r)) return ")";
        return reg_char(r, p - 5'd11);
    endfunction

    // ---------------- decode (combinational from the latched word) ----------------
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = inst_r[6:0];
    assign rd     = inst_r[11:7];
    assign f3     = inst_r[14:12];
    assign rs1    = inst_r[19:15];
    assign rs2    = inst_r[24:20];
    assign f7     = inst_r[31:25];
    assign imm_i  = {{20{inst_r[31]}}, inst_r[31:20]};
    assign imm_s  = {{20{inst_r[31]}}, inst_r[31:25], inst_r[11:7]};
    assign imm_b  = {{19{inst_r[31]}}, inst_r[31], inst_r[7], inst_r[30:25], inst_r[11:8], 1'b0};
    assign imm_u  = {12'd0, inst_r[31:12]};
    assign imm_j  = {{11{inst_r[31]}}, inst_r[31], inst_r[19:12], inst_r[20], inst_r[30:21], 1'b0};

    logic [63:0] d_mnem;
    logic [2:0]  d_mlen;
    logic [7:0]  d_kinds;
    logic [19:0] d_regs;
    logic [31:0] d_imm;
    logic [1:0]  d_ntok;
    logic        d_illegal;

    always_comb begin
        d_mnem    = '0;
        d_mlen    = 3'd0;
        d_illegal = 1'b0;
        d_imm     = imm_i;
        d_ntok    = 2'd3;
        d_kinds   = {2'd0, K_IMM, K_REG, K_REG};
        d_regs    = {10'd0, rs1, rd};
        case (opcode)
            OPC_REG: begin
                d_kinds   = {2'd0, K_REG, K_REG, K_REG};
                d_regs    = {5'd0, rs2, rs1, rd};
                d_illegal = (f7 != 7'd0) && !(f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));
                case (f3)
                    3'd0:    d_mnem = f7[5] ? 64'("sub") : 64'("add");
                    3'd1:    d_mnem = 64'("sll");
                    3'd2:    d_mnem = 64'("slt");
                    3'd3:    d_mnem = 64'("sltu");
                    3'd4:    d_mnem = 64'("xor");
                    3'd5:    d_mnem = f7[5] ? 64'("sra") : 64'("srl");
                    3'd6:    d_mnem = 64'("or");
                    default: d_mnem = 64'("and");
                endcase
            end
            OPC_IMM: begin
                case (f3)
                    3'd0: d_mnem = 64'("addi");
                    3'd1: begin
                        d_mnem    = 64'("slli");
                        d_imm     = {27'd0, rs2};
                        d_illegal = (f7 != 7'd0);
                    end
                    3'd2: d_mnem = 64'("slti");
                    3'd3: d_mnem = 64'("sltiu");
                    3'd4: d_mnem = 64'("xori");
                    3'd5: begin
                        d_mnem    = f7[5] ? 64'("srai") : 64'("srli");
                        d_imm     = {27'd0, rs2};
                        d_illegal = (f7 != 7'd0) && (f7 != 7'b0100000);
                    end
                    3'd6:    d_mnem = 64'("ori");
                    default: d_mnem = 64'("andi");
                endcase
            end
            OPC_LOAD: begin
                d_ntok  = 2'd2;
                d_kinds = {4'd0, K_MEM, K_REG};
                case (f3)
                    3'd0:    d_mnem = 64'("lb");
                    3'd1:    d_mnem = 64'("lh");
                    3'd2:    d_mnem = 64'("lw");
                    3'd4:    d_mnem = 64'("lbu");
                    3'd5:    d_mnem = 64'("lhu");
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                d_ntok  = 2'd2;
                d_kinds = {4'd0, K_MEM, K_REG};
                d_regs  = {10'd0, rs1, rs2};
                d_imm   = imm_s;
                case (f3)
                    3'd0:    d_mnem = 64'("sb");
                    3'd1:    d_mnem = 64'("sh");
                    3'd2:    d_mnem = 64'("sw");
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                d_regs = {10'd0, rs2, rs1};
                d_imm  = imm_b;
                case (f3)
                    3'd0:    d_mnem = 64'("beq");
                    3'd1:    d_mnem = 64'("bne");
                    3'd4:    d_mnem = 64'("blt");
                    3'd5:    d_mnem = 64'("bge");
                    3'd6:    d_mnem = 64'("bltu");
                    3'd7:    d_mnem = 64'("bgeu");
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                d_mnem  = 64'("jal");
                d_ntok  = 2'd2;
                d_kinds = {4'd0, K_IMM, K_REG};
                d_imm   = imm_j;
            end
            OPC_JALR: begin
                d_mnem    = 64'("jalr");
                d_ntok    = 2'd2;
                d_kinds   = {4'd0, K_MEM, K_REG};
                d_illegal = (f3 != 3'd0);
            end
            OPC_LUI, OPC_AUIPC: begin
                d_mnem  = opcode[5] ? 64'("lui") : 64'("auipc");
                d_ntok  = 2'd2;
                d_kinds = {4'd0, K_IMM, K_REG};
                d_imm   = imm_u;
            end
            default: d_illegal = 1'b1;
        endcase
        if (d_illegal) begin
            d_mnem  = 64'("unknown");
            d_ntok  = 2'd1;
            d_kinds = {6'd0, K_IMM};
            d_regs  = '0;
            d_imm   = inst_r;
        end
        // Mnemonic length = index of the highest non-zero byte plus one.
        for (int i = 0; i < 7; i++) begin
            if (d_mnem[8*i +: 8] != 8'h00) d_mlen = 3'(i + 1);
        end
    end

    // ---------------- character generation from the cursor ----------------
    logic [1:0] cur_kind;
    logic [4:0] cur_reg;
    logic [4:0] cur_len;
    logic       cur_last;
    logic [4:0] seg_last;       // last pos of this token, including ", " when not the last token
    logic [2:0] m_sel;
    logic       xfer;

    assign cur_kind = kinds_r[{tok, 1'b0} +: 2];
    assign cur_reg  = regs_r[5*tok +: 5];
    assign cur_len  = tok_len(cur_kind, cur_reg);
    assign cur_last = (tok == ntok_r - 2'd1);
    assign seg_last = cur_last ? cur_len - 5'd1 : cur_len + 5'd1;
    assign m_sel    = mlen_r - 3'd1 - m_idx;
    assign xfer     = char_valid_out && char_ready_in;

    always_comb begin
        char_out = 8'h00;
        case (state)
            S_MNEM: char_out = (m_idx == mlen_r) ? 8'h20 : mnem_r[{m_sel, 3'b000} +: 8];
            S_OPS: begin
                if (pos == cur_len)              char_out = 8'h2C;
                else if (pos == cur_len + 5'd1)  char_out = 8'h20;
                else                             char_out = tok_char(cur_kind, cur_reg, imm_r, pos);
            end
            S_EOL:   char_out = LINE_END;
            default: char_out = 8'h00;
        endcase
    end

    assign char_valid_out = (state == S_MNEM) || (state == S_OPS) || (state == S_EOL);
    assign inst_ready_out = (state == S_IDLE) && !rst_in;
    assign line_done_out  = (state == S_EOL) && char_ready_in;
    assign illegal_out    = line_done_out && illegal_r;

    // ---------------- sequencing ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= S_IDLE;
            inst_r    <= '0;
            mnem_r    <= '0;
            mlen_r    <= 3'd0;
            kinds_r   <= '0;
            regs_r    <= '0;
            imm_r     <= '0;
            ntok_r    <= 2'd0;
            illegal_r <= 1'b0;
            m_idx     <= 3'd0;
            tok       <= 2'd0;
            pos       <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (inst_valid_in) begin
                        inst_r <= inst_in;
                        state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    mnem_r    <= d_mnem;
                    mlen_r    <= d_mlen;
                    kinds_r   <= d_kinds;
                    regs_r    <= d_regs;
                    imm_r     <= d_imm;
                    ntok_r    <= d_ntok;
                    illegal_r <= d_illegal;
                    m_idx     <= 3'd0;
                    state     <= S_MNEM;
                end
                S_MNEM: begin
                    if (xfer) begin
                        if (m_idx == mlen_r) begin
                            tok   <= 2'd0;
                            pos   <= 5'd0;
                            state <= S_OPS;
                        end else begin
                            m_idx <= m_idx + 3'd1;
                        end
                    end
                end
                S_OPS: begin
                    if (xfer) begin
                        if (pos == seg_last) begin
                            pos <= 5'd0;
                            if (cur_last) state <= S_EOL;
                            else          tok   <= tok + 2'd1;
                        end else begin
                            pos <= pos + 5'd1;
                        end
                    end
                end
                S_EOL: begin
                    if (xfer) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_disassembler.sv
// tb/tb_rv32i_disassembler.sv - directed self-checking bench for rv32i_disassembler
module tb_rv32i_disassembler;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [7:0]  char_o;
    logic        char_valid;
    logic        char_ready;
    logic        line_done;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv32i_disassembler dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .inst_in        (inst),
        .inst_valid_in  (inst_valid),
        .inst_ready_out (inst_ready),
        .char_out       (char_o),
        .char_valid_out (char_valid),
        .char_ready_in  (char_ready),
        .line_done_out  (line_done),
        .illegal_out    (illegal)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pack_str(input string s);
        logic [255:0] v = '0;
        for (int i = 0; i < s.len(); i++) v = {v[247:0], s[i]};
        return v;
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (!inst_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("ready_timeout", inst_ready, 1'b1);
    endtask

    // Collect one line starting at the current negedge; optionally stall after stall_at chars.
    task automatic recv_line(input int stall_at, output logic [255:0] line, output logic ill);
        logic [7:0] held;
        int         n = 0;
        int         stall = stall_at;
        logic       done = 1'b0;
        line = '0;
        ill  = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (stall >= 0 && n == stall && char_valid) begin
                char_ready = 1'b0;
                held = char_o;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_valid", char_valid, 1'b1);
                    check("bp_hold", char_o, held);
                    check("bp_no_done", line_done, 1'b0);
                end
                char_ready = 1'b1;
                stall = -1;
                #1;
            end
            if (char_valid && char_ready) begin
                line = {line[247:0], char_o};
                n++;
                if (line_done) begin
                    done = 1'b1;
                    ill  = illegal;
                end
            end
            @(negedge clk);
        end
        check("line_done_seen", done, 1'b1);
    endtask

    task automatic run_vec(input int idx, input logic [31:0] w, input string txt,
                           input logic exp_ill, input int stall_at, input logic busy_poke);
        logic [255:0] line;
        logic         ill;
        wait_ready();
        inst = w;
        inst_valid = 1'b1;
        @(negedge clk);
        if (busy_poke) begin
            inst = 32'hFFFF_FFFF;
            check("busy_ready", inst_ready, 1'b0);
        end else begin
            inst_valid = 1'b0;
        end
        check("lat_n1", char_valid, 1'b0);
        @(negedge clk);
        inst_valid = 1'b0;
        check("lat_n2", char_valid, 1'b1);
        recv_line(stall_at, line, ill);
        check($sformatf("line%0d", idx), line, pack_str(txt));
        check($sformatf("illegal%0d", idx), ill, exp_ill);
        check("idle_valid", char_valid, 1'b0);
        check("idle_ready", inst_ready, 1'b1);
        @(negedge clk);
        check("idle_quiet", char_valid, 1'b0);
    endtask

    logic [31:0] v_inst [12];
    string       v_txt  [12];
    logic        v_ill  [12];

    initial begin
        v_inst[0]  = 32'h0050_0093; v_txt[0]  = "addi x1, x0, 0x00000005\n";   v_ill[0]  = 1'b0;
        v_inst[1]  = 32'h0021_A423; v_txt[1]  = "sw x2, 0x00000008(x3)\n";     v_ill[1]  = 1'b0;
        v_inst[2]  = 32'hFE20_8EE3; v_txt[2]  = "beq x1, x2, 0xfffffffc\n";    v_ill[2]  = 1'b0;
        v_inst[3]  = 32'h1234_52B7; v_txt[3]  = "lui x5, 0x00012345\n";        v_ill[3]  = 1'b0;
        v_inst[4]  = 32'hFFFF_FFFF; v_txt[4]  = "unknown 0xffffffff\n";        v_ill[4]  = 1'b1;
        v_inst[5]  = 32'h4000_7033; v_txt[5]  = "unknown 0x40007033\n";        v_ill[5]  = 1'b1;
        v_inst[6]  = 32'h414F_8533; v_txt[6]  = "sub x10, x31, x20\n";         v_ill[6]  = 1'b0;
        v_inst[7]  = 32'h41F2_5193; v_txt[7]  = "srai x3, x4, 0x0000001f\n";   v_ill[7]  = 1'b0;
        v_inst[8]  = 32'hFFF1_2383; v_txt[8]  = "lw x7, 0xffffffff(x2)\n";     v_ill[8]  = 1'b0;
        v_inst[9]  = 32'h8000_006F; v_txt[9]  = "jal x0, 0xfff00000\n";        v_ill[9]  = 1'b0;
        v_inst[10] = 32'h0000_1067; v_txt[10] = "unknown 0x00001067\n";        v_ill[10] = 1'b1;
        v_inst[11] = 32'h0002_80E7; v_txt[11] = "jalr x1, 0x00000000(x5)\n";   v_ill[11] = 1'b0;

        rst = 1'b1;
        inst = '0;
        inst_valid = 1'b0;
        char_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", char_valid, 1'b0);
        check("rst_char", char_o, 8'h00);
        check("rst_done", line_done, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_ready", inst_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", inst_ready, 1'b1);

        for (int i = 0; i < 12; i++) begin
            run_vec(i, v_inst[i], v_txt[i], v_ill[i], (i == 3) ? 6 : -1, i == 1);
        end

        // Reset in the middle of a line.
        wait_ready();
        inst = v_inst[0];
        inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_valid", char_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", char_valid, 1'b0);
        check("midrst_ready", inst_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rel_ready", inst_ready, 1'b1);
        check("midrst_rel_valid", char_valid, 1'b0);
        run_vec(12, v_inst[1], v_txt[1], v_ill[1], 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
